bus_server: RTL and testbench

- Responder at the server end of the bus arbiter's server interface.
- Accepts one forwarded client transaction at a time: read or write, tagged with the originating client ID.
- Services it against an internal register file after a programmable number of wait states.
- Returns a tagged response so the arbiter can route it back to the correct client (1 of 4).

---
 rtl/bus_server_pkg.sv | 28 ++
 rtl/bus_server_regfile.sv | 31 +++
 rtl/bus_server.sv | 115 +++++++++++
 tb/tb_bus_server.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_server_pkg.sv
// Protocol constants shared by the bus arbiter and the bus server:
// client tags, FSM state encodings and arbitration policy codes.
package bus_server_pkg;

    localparam int ID_WIDTH_DEFAULT = 2;

    localparam logic [1:0] CLIENT_1 = 2'd0;
    localparam logic [1:0] CLIENT_2 = 2'd1;
    localparam logic [1:0] CLIENT_3 = 2'd2;
    localparam logic [1:0] CLIENT_4 = 2'd3;

    localparam int PRIORITY_STRICT = 0;
    localparam int PRIORITY_RR     = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // The counter is loaded on WAIT entry and counts down to zero, so it
    // starts one below the number of wait states.
    function automatic logic [3:0] wait_load(input int wait_cycles);
        return (wait_cycles > 0) ? 4'(wait_cycles - 1) : 4'd0;
    endfunction

endpackage

// File: rtl/bus_server_regfile.sv
// Register file behind the bus server: flop array with async clear,
// one synchronous write port and one combinational read port.
module bus_server_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_server.sv
// Bus server: accepts one tagged client transaction at a time, services it
// against the register file after WAIT_CYCLES wait states, returns a tagged response.
module bus_server
    import bus_server_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int ID_WIDTH    = ID_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [ID_WIDTH-1:0]   req_id,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ID_WIDTH-1:0]   rsp_id,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int         IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

    state_t                state;
    state_t                next_state;
    logic [3:0]            wait_cnt;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [ID_WIDTH-1:0]   lat_id;
    logic [DATA_WIDTH-1:0] rf_rdata;
    logic                  addr_ok;
    logic                  rf_we;
    logic                  accept;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign addr_ok   = (32'(lat_addr) < 32'(DEPTH));
    assign rf_we     = (state == ST_ACCESS) && lat_we && addr_ok;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (req_valid) next_state = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
            ST_WAIT:   if (wait_cnt == 4'd0) next_state = ST_ACCESS;
            ST_ACCESS: next_state = ST_RESP;
            ST_RESP:   if (rsp_ready) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The request is captured at acceptance so the arbiter is free to move on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_id    <= '0;
        end else if (accept) begin
            wait_cnt  <= WAIT_LOAD;
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_id    <= req_id;
        end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Read data is the pre-write value; errors and writes return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
        end else if (state == ST_ACCESS) begin
            rsp_rdata <= (addr_ok && !lat_we) ? rf_rdata : '0;
            rsp_id    <= lat_id;
            rsp_err   <= !addr_ok;
        end
    end

    bus_server_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_regfile (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (rf_we),
        .waddr(lat_addr[IDX_WIDTH-1:0]),
        .wdata(lat_wdata),
        .raddr(lat_addr[IDX_WIDTH-1:0]),
        .rdata(rf_rdata)
    );

endmodule

// File: tb/tb_bus_server.sv
// Testbench for bus_server: table-driven transactions on a WAIT_CYCLES=2 instance,
// plus hand sequences for backpressure, WAIT_CYCLES=0 throughput and reset mid-operation.
module tb_bus_server;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_id;

    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_id;

    logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0, busy0;
    logic [31:0] rsp_rdata0;
    logic [1:0]  rsp_id0;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  id;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vector_t;

    vector_t vectors [10];

    always #5 clk = ~clk;

    bus_server #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_id(req_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
    );

    bus_server #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_id(req_id),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
        .rsp_id(rsp_id0), .rsp_err(rsp_err0), .busy(busy0)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one transaction to the selected instance; returns response and latency in
    // cycles counted from the acceptance cycle. Called just after a rising edge.
    task automatic apply_stimulus(input bit sel, input logic we, input logic [7:0] addr,
                                  input logic [31:0] wdata, input logic [1:0] id,
                                  output logic [31:0] rdata, output logic err,
                                  output logic [1:0] rid, output int lat);
        bit got;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_id    = id;
        if (sel) req_valid0 = 1'b1; else req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sel ? req_ready0 : req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_output("accept_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        req_valid  = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (sel ? rsp_valid0 : rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_output("response_timeout", 32'(got), 32'd1);
        rdata = sel ? rsp_rdata0 : rsp_rdata;
        err   = sel ? rsp_err0 : rsp_err;
        rid   = sel ? rsp_id0 : rsp_id;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  rid;
        int          lat;
        int          acc_cycle;
        logic [1:0]  next_id;
        logic [1:0]  exp_rsp_id;

        vectors[0] = '{1'b0, 8'd5,   32'h0,        2'd0, 32'h0,        1'b0};
        vectors[1] = '{1'b1, 8'd3,   32'hDEADBEEF, 2'd2, 32'h0,        1'b0};
        vectors[2] = '{1'b0, 8'd3,   32'h0,        2'd1, 32'hDEADBEEF, 1'b0};
        vectors[3] = '{1'b1, 8'd16,  32'h12345678, 2'd3, 32'h0,        1'b1};
        vectors[4] = '{1'b0, 8'd16,  32'h0,        2'd0, 32'h0,        1'b1};
        vectors[5] = '{1'b0, 8'd0,   32'h0,        2'd2, 32'h0,        1'b0};
        vectors[6] = '{1'b1, 8'd15,  32'h0F0F0F0F, 2'd3, 32'h0,        1'b0};
        vectors[7] = '{1'b0, 8'd15,  32'h0,        2'd3, 32'h0F0F0F0F, 1'b0};
        vectors[8] = '{1'b1, 8'd255, 32'hFFFFFFFF, 2'd1, 32'h0,        1'b1};
        vectors[9] = '{1'b0, 8'd3,   32'h0,        2'd0, 32'hDEADBEEF, 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0;
        rsp_ready = 1'b1; rsp_ready0 = 1'b1;
        req_we = 1'b0; req_addr = '0; req_wdata = '0; req_id = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_req_ready", 32'(req_ready), 32'd1);
        check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_rsp_rdata", rsp_rdata, 32'h0);
        check_output("reset0_req_ready", 32'(req_ready0), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 10; v++) begin
            apply_stimulus(1'b0, vectors[v].we, vectors[v].addr, vectors[v].wdata, vectors[v].id,
                           rdata, err, rid, lat);
            check_output($sformatf("vec%0d_rdata", v), rdata, vectors[v].exp_rdata);
            check_output($sformatf("vec%0d_err", v), 32'(err), 32'(vectors[v].exp_err));
            check_output($sformatf("vec%0d_id", v), 32'(rid), 32'(vectors[v].id));
            check_output($sformatf("vec%0d_latency", v), 32'(lat), 32'd4);
        end
        @(negedge clk);
        check_output("idle_after_handshake_busy", 32'(busy), 32'd0);
        check_output("idle_after_handshake_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Backpressure: response must hold while stray requests are ignored
        rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 8'd3; req_id = 2'd1; req_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_output("bp_busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_output("bp_response_seen", 32'(rsp_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            check_output($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'd1);
            check_output($sformatf("bp%0d_rdata", c), rsp_rdata, 32'hDEADBEEF);
            check_output($sformatf("bp%0d_id", c), 32'(rsp_id), 32'd1);
            check_output($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            req_we    = 1'b1;
            req_addr  = 8'd3;
            req_wdata = 32'h11111111;
            req_valid = (c % 2 == 0) && (c < 8);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("bp_busy_released", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        apply_stimulus(1'b0, 1'b0, 8'd3, 32'h0, 2'd2, rdata, err, rid, lat);
        check_output("bp_ignored_write", rdata, 32'hDEADBEEF);

        // WAIT_CYCLES=0: single transaction latency, then back-to-back throughput
        apply_stimulus(1'b1, 1'b1, 8'd9, 32'hCAFEF00D, 2'd3, rdata, err, rid, lat);
        check_output("w0_write_latency", 32'(lat), 32'd2);
        check_output("w0_write_id", 32'(rid), 32'd3);
        apply_stimulus(1'b1, 1'b0, 8'd9, 32'h0, 2'd0, rdata, err, rid, lat);
        check_output("w0_read_data", rdata, 32'hCAFEF00D);
        check_output("w0_read_latency", 32'(lat), 32'd2);

        req_we = 1'b0; req_addr = 8'd9; next_id = 2'd1; req_id = next_id;
        exp_rsp_id = 2'd0;
        req_valid0 = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check_output($sformatf("w0_c%0d_ready", c), 32'(req_ready0), 32'((c % 3) == 0));
            check_output($sformatf("w0_c%0d_valid", c), 32'(rsp_valid0), 32'((c % 3) == 2));
            if ((c % 3) == 0) exp_rsp_id = next_id;
            if ((c % 3) == 2) begin
                check_output($sformatf("w0_c%0d_id", c), 32'(rsp_id0), 32'(exp_rsp_id));
                check_output($sformatf("w0_c%0d_rdata", c), rsp_rdata0, 32'hCAFEF00D);
            end
            acc_cycle = req_ready0 ? 1 : 0;
            @(posedge clk);
            #1;
            if (acc_cycle == 1) begin
                next_id = next_id + 2'd1;
                req_id  = next_id;
            end
        end
        req_valid0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during WAIT discards the pending write and clears the array
        req_we = 1'b1; req_addr = 8'd7; req_wdata = 32'hA5A5A5A5; req_id = 2'd2;
        req_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_output("rst_mid_in_wait", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_async_req_ready", 32'(req_ready), 32'd1);
        check_output("rst_async_busy", 32'(busy), 32'd0);
        check_output("rst_async_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("rst_async_rsp_rdata", rsp_rdata, 32'h0);
        check_output("rst_async_rsp_id", 32'(rsp_id), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(1'b0, 1'b0, 8'd7, 32'h0, 2'd1, rdata, err, rid, lat);
        check_output("rst_read7", rdata, 32'h0);
        check_output("rst_read7_err", 32'(err), 32'd0);
        apply_stimulus(1'b0, 1'b0, 8'd3, 32'h0, 2'd1, rdata, err, rid, lat);
        check_output("rst_read3_cleared", rdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
